// File: rtl/lo_quad_gen.sv
// Quadrature local oscillator: a programmable phase accumulator drives a quarter-wave
// sine table; quadrant folding yields matched cosine (I) and sine (Q) samples, 2-cycle latency.
module lo_quad_gen #(
    parameter int          BIT_WIDTH    = 14,
    parameter int          TABLE_BITS   = 4,
    parameter int          PHASE_BITS   = 16,
    parameter int unsigned DEFAULT_STEP = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PHASE_BITS-1:0] step_in,
    input  logic                  step_load,
    input  logic                  phase_clr,
    output logic [BIT_WIDTH-1:0]  i_out,
    output logic [BIT_WIDTH-1:0]  q_out,
    output logic                  valid
);

    localparam int                    N         = 1 << TABLE_BITS;
    localparam logic [PHASE_BITS-1:0] RST_STEP  = PHASE_BITS'(DEFAULT_STEP);
    localparam longint                HALF_PI_S = 64'sd1686629713;  // pi/2 in Q30

    // Integer Taylor series in Q30 so the table is built without real arithmetic.
    function automatic logic [BIT_WIDTH-1:0] sin_entry(input int k);
        longint x, x2, term, acc, amp;
        x    = (HALF_PI_S * longint'(k)) / longint'(N);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            acc  = acc + term;
        end
        amp = (longint'(1) <<< (BIT_WIDTH - 1)) - 1;
        return BIT_WIDTH'((amp * acc + (longint'(1) <<< 29)) >>> 30);
    endfunction

    logic [BIT_WIDTH-1:0] tab [0:N];

    for (genvar k = 0; k <= N; k++) begin : g_tab
        localparam logic [BIT_WIDTH-1:0] TV = sin_entry(k);
        assign tab[k] = TV;
    end

    logic [PHASE_BITS-1:0] ph_q, ph_d;
    logic [PHASE_BITS-1:0] step_q, step_d;
    logic [1:0]            quad;
    logic [TABLE_BITS:0]   off, off_c;

    assign quad  = ph_q[PHASE_BITS-1 -: 2];
    assign off   = {1'b0, ph_q[PHASE_BITS-3 -: TABLE_BITS]};
    assign off_c = (TABLE_BITS + 1)'(N) - off;

    always_comb begin
        ph_d   = ph_q;
        step_d = step_q;
        if (phase_clr) begin
            ph_d = '0;
        end else if (en) begin
            ph_d = ph_q + step_q;
        end
        if (step_load) begin
            step_d = step_in;
        end
    end

    logic [BIT_WIDTH-1:0]        t_o_q, t_no_q;
    logic [1:0]                  quad_q;
    logic                        v1_q;
    logic signed [BIT_WIDTH-1:0] s_o, s_no, sin_d, cos_d;
    logic [BIT_WIDTH-1:0]        i_q, q_q;
    logic                        valid_q;

    assign s_o  = $signed(t_o_q);
    assign s_no = $signed(t_no_q);

    // Table magnitudes never exceed A, so negation cannot overflow.
    always_comb begin
        sin_d = s_o;
        cos_d = s_no;
        case (quad_q)
            2'd0: begin sin_d = s_o;   cos_d = s_no;  end
            2'd1: begin sin_d = s_no;  cos_d = -s_o;  end
            2'd2: begin sin_d = -s_o;  cos_d = -s_no; end
            default: begin sin_d = -s_no; cos_d = s_o; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q    <= '0;
            step_q  <= RST_STEP;
            v1_q    <= 1'b0;
            valid_q <= 1'b0;
            i_q     <= '0;
            q_q     <= '0;
        end else begin
            ph_q    <= ph_d;
            step_q  <= step_d;
            v1_q    <= en;
            valid_q <= v1_q;
            if (en) begin
                t_o_q  <= tab[off];
                t_no_q <= tab[off_c];
                quad_q <= quad;
            end
            // Outputs hold their last sample across gaps.
            if (v1_q) begin
                i_q <= cos_d;
                q_q <= sin_d;
            end
        end
    end

    assign i_out = i_q;
    assign q_out = q_q;
    assign valid = valid_q;

endmodule

// File: doc/lo_quad_gen.md
# lo_quad_gen

Parametrised quadrature local-oscillator generator for the SFCW receive chain's second LO. A phase accumulator drives a quarter-wave sine table, and quadrant folding produces matched cosine (I) and sine (Q) samples from the same phase. Unlike the fixed-period single-output LO, this block has a runtime-programmable phase step, sample enable, phase clear and a valid flag. It feeds the I/Q mixers directly.

## Interface
- BIT_WIDTH, 14, signed output width; amplitude A = 2^(BIT_WIDTH-1)-1
- TABLE_BITS, 4, quarter-wave resolution; N = 2^TABLE_BITS, table holds N+1 entries (k = 0..N)
- PHASE_BITS, 16, accumulator width; must satisfy PHASE_BITS >= TABLE_BITS+2
- DEFAULT_STEP, 1024, phase step loaded at reset
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  sample enable; one sample is produced per cycle with en=1
- step_in  input  PHASE_BITS  new phase step value (unsigned)
- step_load  input  1  1-cycle strobe; captures step_in
- phase_clr  input  1  forces the accumulator to 0
- i_out  output  BIT_WIDTH  signed cosine sample
- q_out  output  BIT_WIDTH  signed sine sample
- valid  output  1  high when i_out/q_out hold a new sample

## Operation
- Table: T[k] = round(A·sin(π/2·k/N)), computed at elaboration and read-only. T[0]=0, T[N]=A.
- Phase decode for accumulator ph:
  - Quadrant q = ph[PHASE_BITS-1 -: 2].
  - Offset o = ph[PHASE_BITS-3 -: TABLE_BITS].
  - Lower bits are truncated, with no dithering.
- Sine (Q) by quadrant: q0 → T[o], q1 → T[N-o], q2 → -T[o], q3 → -T[N-o].
- Cosine (I) by quadrant: q0 → T[N-o], q1 → -T[o], q2 → -T[N-o], q3 → T[o].
- Negation is two's complement. Since |T| ≤ A, it never overflows, and -0 yields 0.
- Accumulator:
  - When en=1, the current ph is sampled, then ph <= ph + step, wrapping modulo 2^PHASE_BITS.
  - When en=0, ph holds.
- Step register:
  - step_load=1 sets step <= step_in.
  - The new step applies to the first accumulation after the load cycle. The accumulation in the load cycle itself uses the old step.
  - step=0 produces a constant output.
- phase_clr=1 sets ph <= 0, regardless of en.
  - If en=1 in the same cycle, the sample taken uses the old ph, and the next sample uses phase 0.
- Priority: rst > phase_clr > en accumulation. step_load is independent and may coincide with any of these except rst.
- Reset values:
  - ph=0, step=DEFAULT_STEP.
  - i_out=0, q_out=0, valid=0.
  - Pipeline valid bits are cleared.
  - A reset mid-stream discards in-flight samples, so no valid pulse emerges from the pre-reset pipeline.

## Timing
- Pipeline is two stages:
  - Stage 1 registers the table reads T[o] and T[N-o], plus q.
  - Stage 2 registers the signed, folded i_out/q_out.
- Latency: a sample taken at cycle n (en=1) appears on i_out/q_out with valid=1 at cycle n+2.
- valid is en delayed by 2 cycles. Continuous en gives continuous valid.
- When valid=0, i_out/q_out hold their last value and do not return to 0, except after reset.
- Throughput: one sample per clock. There is no backpressure.
- The first valid sample after reset with en=1 at cycle r+1 (r = last reset cycle) appears at cycle r+3, at phase 0: I=A, Q=0.

## Test plan
- Reset, then en=1 continuously with step 4096 (defaults otherwise):
  - Q sequence from first valid is 0, 3135, 5792, 7567, 8191, 7567, 5792, 3135, 0, -3135, -5792, -7567, -8191, -7567, -5792, -3135, repeating with period 16.
  - I is the same sequence shifted by 4 samples, starting 8191.
  - Check valid timing: 2-cycle latency.
- Default step 1024, 64 samples:
  - Period is 64.
  - I²+Q² stays within 2·A of A² for every sample.
  - Samples 16/32/48 equal (0, 8191), (-8191, 0), (0, -8191).
- en toggled 1,0,0,1 with step 4096:
  - valid follows en delayed by 2.
  - Outputs hold during gaps.
  - Sample sequence is contiguous (0, 3135, 5792 …), with no phase skipped.
- step_load of 8192 while running at 4096:
  - The load-cycle sample advances by 4096.
  - Subsequent samples advance by 8192, so Q steps 0 → 5792 → 8191 → 5792 → 0.
- phase_clr with en=1 mid-stream:
  - The sample after the clear-cycle sample is I=8191, Q=0.
  - Assert phase_clr together with step_load and confirm both take effect.
- rst asserted for 1 cycle mid-stream:
  - valid drops the cycle after reset.
  - No stale samples emerge.
  - step returns to 1024.
  - Restart gives I=8191, Q=0 first.
